pio_in_conditioner: RTL
=======================

// Module: pio_in_conditioner
// PURPOSE
//  Consumes the O output of a bank input buffer (IB/BB). Owns the bank's
//  BCINRD.INRDENI line and sequences it on enable, then waits a settle time.
//  Once settled, synchronises, glitch-filters and edge-detects the pad level
//  for fabric logic. Counts rejected glitches for bank-reference characterisation.
// PARAMETERS
//  SYNC_STAGES    2   synchroniser flops on pad_i (>=2)
//  SETTLE_CYCLES  64  cycles INRDENI is held before the input is trusted (>=1)
//  FILTER_LEN     4   consecutive mismatching samples needed to change level (>=1)
//  GCNT_W         8   glitch counter width
// PORTS
//  clk           in   1       single clock, all state on rising edge
//  resetn        in   1       asynchronous, active-low reset
//  enable_i      in   1       request bank input path on (level-sensitive)
//  pad_i         in   1       IB/BB .O, asynchronous to clk
//  clr_glitch_i  in   1       synchronous clear of glitch_cnt_o
//  inrd_en_o     out  1       to BCINRD.INRDENI
//  ready_o       out  1       high while in RUN
//  level_o       out  1       filtered pad level
//  rise_o        out  1       1-cycle pulse on level_o 0->1
//  fall_o        out  1       1-cycle pulse on level_o 1->0
//  glitch_cnt_o  out  GCNT_W  saturating count of rejected pulses
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, sync chain 0, counters 0.
//  FSM (registered, one-hot or binary):
//   IDLE   : inrd_en_o=0, ready_o=0. enable_i=1 -> SETTLE, settle_cnt<=0.
//   SETTLE : inrd_en_o=1. settle_cnt++ each cycle; settle_cnt==SETTLE_CYCLES-1
//            -> RUN. enable_i=0 -> IDLE, no further effect.
//   RUN    : inrd_en_o=1, ready_o=1. enable_i=0 -> IDLE.
//  Timing: enable_i sampled high at edge E -> inrd_en_o=1 after E,
//   ready_o=1 after edge E+SETTLE_CYCLES.
//  Sync chain runs in every state; sync_q = last stage.
//  On the SETTLE->RUN edge: level_o<=sync_q, filt_cnt<=0, no rise/fall pulse.
//  Filter (RUN only): sync_q!=level_o -> filt_cnt++; when filt_cnt==FILTER_LEN-1
//   and still mismatching: level_o<=sync_q, filt_cnt<=0, pulse rise_o/fall_o.
//   sync_q==level_o with filt_cnt!=0 -> glitch: filt_cnt<=0, glitch_cnt_o++.
//  Latency: pad change first sampled at edge N -> level_o and the pulse update
//   at edge N+SYNC_STAGES+FILTER_LEN-1 (defaults: N+5).
//  glitch_cnt_o saturates at all-ones. clr_glitch_i wins over a simultaneous
//   increment (result 0). Counter is preserved across IDLE.
//  Leaving RUN/SETTLE (enable_i=0): at the next edge level_o, rise_o, fall_o,
//   ready_o, inrd_en_o and filt_cnt all go to 0. No pulses are emitted.
//  Reset mid-operation: immediate return to reset values. No partial pulse.
//  rise_o and fall_o are never high together. They are never high outside RUN.
// STRUCTURE
//  pio_in_pkg: FSM state enum, clog2-based width helpers for settle_cnt and
//   filt_cnt, parameter-legality checks.
//  Sub-module pio_sync_chain #(SYNC_STAGES): async-reset flop chain with
//   ASYNC_REG attribute. FSM, filter and counters stay in this module.
// TESTING
//  1 reset, enable_i=1 at edge 10, SETTLE_CYCLES=64 -> inrd_en_o=1 after 10,
//    ready_o=1 after edge 74. pad_i=1 held -> level_o=1 at entry, no rise_o.
//  2 RUN, level 0. pad_i 0->1 stable, first sampled at edge 100 -> level_o=1 and
//    rise_o pulse at edge 105 only. Same for 1->0 with fall_o.
//  3 RUN, 3-cycle pad_i high pulse (FILTER_LEN=4) -> level_o stays 0,
//    glitch_cnt_o 0->1. 300 such pulses -> glitch_cnt_o=255 (saturated).
//  4 clr_glitch_i in the same cycle as a glitch increment -> glitch_cnt_o=0.
//  5 enable_i dropped at SETTLE cycle 30 -> IDLE next edge, inrd_en_o=0, ready_o
//    never asserted. Re-enable -> full 64-cycle settle restarts.
//  6 resetn low during a pending level change (filt_cnt=2) -> all outputs 0
//    at once, no rise_o. glitch_cnt_o=0 after release.

Source files
------------

// File: rtl/pio_in_pkg.sv
// ============================================================================
// pio_in_pkg : shared types, width helpers and parameter checks
// Rev 1.0
// ============================================================================
`default_nettype none

package pio_in_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   // A counter that reaches n-1 needs clog2(n) bits, but never fewer than one.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic bit params_ok(input int sync_stages, input int settle_cycles,
                                    input int filter_len, input int gcnt_w);
      return (sync_stages >= 2) && (settle_cycles >= 1) &&
             (filter_len >= 1) && (gcnt_w >= 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pio_sync_chain.sv
// ============================================================================
// pio_sync_chain : multi-flop synchroniser for an asynchronous pad level
// Rev 1.0
// ============================================================================
`default_nettype none

module pio_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d_i};
      end
   end

   assign q_o = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pio_in_conditioner.sv
// ============================================================================
// pio_in_conditioner : INRDENI sequencing, settle wait, sync, glitch filter,
//                      edge detect and glitch counting for a bank input pad
// Rev 1.0
// ============================================================================
`default_nettype none

module pio_in_conditioner
   import pio_in_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 64,
   parameter int FILTER_LEN    = 4,
   parameter int GCNT_W        = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable_i,
   input  logic              pad_i,
   input  logic              clr_glitch_i,
   output logic              inrd_en_o,
   output logic              ready_o,
   output logic              level_o,
   output logic              rise_o,
   output logic              fall_o,
   output logic [GCNT_W-1:0] glitch_cnt_o
);

   localparam int                C_SET_W       = cnt_w(SETTLE_CYCLES);
   localparam int                C_FILT_W      = cnt_w(FILTER_LEN);
   localparam logic [C_SET_W-1:0]  C_SETTLE_LAST = C_SET_W'(SETTLE_CYCLES - 1);
   localparam logic [C_FILT_W-1:0] C_FILT_LAST   = C_FILT_W'(FILTER_LEN - 1);

   if (!params_ok(SYNC_STAGES, SETTLE_CYCLES, FILTER_LEN, GCNT_W)) begin : g_param_check
      $error("pio_in_conditioner: illegal parameter set");
   end

   state_t               r_state;
   logic [C_SET_W-1:0]   r_settle_cnt;
   logic [C_FILT_W-1:0]  r_filt_cnt;
   logic [GCNT_W-1:0]    r_gcnt;
   logic                 r_inrd_en, r_ready, r_level, r_rise, r_fall;
   logic                 w_sync_q;
   logic                 w_glitch;

   pio_sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d_i    (pad_i),
      .q_o    (w_sync_q)
   );

   // A mismatch run that ends before reaching FILTER_LEN samples is a rejected pulse.
   assign w_glitch = (r_state == ST_RUN) && enable_i &&
                     (w_sync_q == r_level) && (r_filt_cnt != '0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= '0;
         r_filt_cnt   <= '0;
         r_inrd_en    <= 1'b0;
         r_ready      <= 1'b0;
         r_level      <= 1'b0;
         r_rise       <= 1'b0;
         r_fall       <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_ready    <= 1'b0;
               r_level    <= 1'b0;
               r_filt_cnt <= '0;
               if (enable_i) begin
                  r_state      <= ST_SETTLE;
                  r_settle_cnt <= '0;
                  r_inrd_en    <= 1'b1;
               end else begin
                  r_inrd_en <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (!enable_i) begin
                  r_state   <= ST_IDLE;
                  r_inrd_en <= 1'b0;
               end else if (r_settle_cnt == C_SETTLE_LAST) begin
                  r_state    <= ST_RUN;
                  r_ready    <= 1'b1;
                  r_level    <= w_sync_q;
                  r_filt_cnt <= '0;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (!enable_i) begin
                  r_state    <= ST_IDLE;
                  r_inrd_en  <= 1'b0;
                  r_ready    <= 1'b0;
                  r_level    <= 1'b0;
                  r_filt_cnt <= '0;
               end else if (w_sync_q != r_level) begin
                  if (r_filt_cnt == C_FILT_LAST) begin
                     r_level    <= w_sync_q;
                     r_filt_cnt <= '0;
                     r_rise     <= w_sync_q;
                     r_fall     <= ~w_sync_q;
                  end else begin
                     r_filt_cnt <= r_filt_cnt + 1'b1;
                  end
               end else begin
                  r_filt_cnt <= '0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_inrd_en <= 1'b0;
               r_ready   <= 1'b0;
               r_level   <= 1'b0;
            end
         endcase
      end
   end

   // Held across IDLE so characterisation data survives a disable.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_gcnt <= '0;
      end else if (clr_glitch_i) begin
         r_gcnt <= '0;
      end else if (w_glitch && (r_gcnt != {GCNT_W{1'b1}})) begin
         r_gcnt <= r_gcnt + 1'b1;
      end
   end

   assign inrd_en_o    = r_inrd_en;
   assign ready_o      = r_ready;
   assign level_o      = r_level;
   assign rise_o       = r_rise;
   assign fall_o       = r_fall;
   assign glitch_cnt_o = r_gcnt;

endmodule

`default_nettype wire
